// File: rtl/arm_mem_pkg.sv
// Shared definitions for the arm core data-bus responder.
// Holds the MMIO page base, the register offsets within that page, the
// STATUS register bit layout and the address-decode helper that maps a
// core address onto one of the responder's targets.
package arm_mem_pkg;

    // Upper half-word that selects the MMIO page
    localparam logic [15:0] MMIO_BASE_HI = 16'hFFFF;

    // Register offsets inside the MMIO page (byte offsets, word aligned)
    localparam logic [7:0] OFF_LED    = 8'h00;
    localparam logic [7:0] OFF_TIMER  = 8'h04;
    localparam logic [7:0] OFF_TXDATA = 8'h08;
    localparam logic [7:0] OFF_STATUS = 8'h0C;

    // STATUS register layout
    localparam int ST_FULL      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_COUNT_LSB = 8;
    localparam int ST_COUNT_W   = 4;

    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_LED,
        SEL_TIMER,
        SEL_TX,
        SEL_STATUS,
        SEL_NONE
    } mmio_sel_e;

    // Address decode. Only the page half-word and the word offset matter:
    // byte-lane bits are ignored because the bus is word-only.
    function automatic mmio_sel_e decode_addr(input logic [15:0] page,
                                              input logic [5:0]  word_off);
        mmio_sel_e sel;
        if (page != MMIO_BASE_HI) begin
            sel = SEL_RAM;
        end else begin
            case ({word_off, 2'b00})
                OFF_LED:    sel = SEL_LED;
                OFF_TIMER:  sel = SEL_TIMER;
                OFF_TXDATA: sel = SEL_TX;
                OFF_STATUS: sel = SEL_STATUS;
                default:    sel = SEL_NONE;
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// Byte FIFO feeding the TX valid/ready stream.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   push, push_data       enqueue request and byte
//   pop                   dequeue request (ignored when empty)
//   pop_data              head byte, combinational from storage
//   full, empty, count    occupancy flags and entry count (0..DEPTH)
// A push while full is dropped unless a pop happens on the same edge, in
// which case both take effect and the count is unchanged. Reset empties the
// queue by clearing pointers; storage contents are left alone.
module tx_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  pop_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // A pop frees a slot on the same edge, so a full FIFO may still accept
    // a push when the consumer is draining it.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so the
    // pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/arm_dbus_responder.sv
// Memory end of the single-cycle arm core's data port.
// Word RAM plus an MMIO page (0xFFFF_xxxx) with an LED register, a
// free-running timer, a TX byte FIFO and its STATUS register.
// Ports:
//   clk, reset             clock and synchronous active-high reset
//   MemWrite               store strobe, committed at the clock edge
//   ALUResult              byte address from the core
//   WriteData              store data from the core
//   ReadData               load data, combinational from ALUResult
//   tx_data, tx_valid      FIFO head byte and non-empty flag
//   tx_ready               consumer accepts the head on tx_valid && tx_ready
//   leds                   LED register contents
module arm_dbus_responder
    import arm_mem_pkg::*;
#(
    parameter int RAM_AW     = 6,
    parameter int FIFO_DEPTH = 8,
    parameter int LED_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemWrite,
    input  logic [31:0]       ALUResult,
    input  logic [31:0]       WriteData,
    output logic [31:0]       ReadData,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [LED_W-1:0]  leds
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    mmio_sel_e         sel;
    logic              wr_en;
    logic [RAM_AW-1:0] ram_idx;
    logic [31:0]       ram [2**RAM_AW];
    logic [LED_W-1:0]  led_q;
    logic [31:0]       timer_q;
    logic              ovf_q;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [31:0]       status_word;
    logic              unused_addr_bits;

    // Bits 15:8 of an MMIO address and the byte lane never affect decode.
    assign unused_addr_bits = &{1'b0, ALUResult[15:8], ALUResult[1:0]};

    assign sel     = decode_addr(ALUResult[31:16], ALUResult[7:2]);
    assign ram_idx = ALUResult[RAM_AW+1:2];

    // Stores issued during a reset cycle are discarded everywhere.
    assign wr_en = MemWrite && !reset;

    assign fifo_push = wr_en && (sel == SEL_TX);
    assign fifo_pop  = tx_valid && tx_ready;
    assign tx_valid  = !fifo_empty;
    assign leds      = led_q;

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8),
        .CW    (CNT_W)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (WriteData[7:0]),
        .pop       (fifo_pop),
        .pop_data  (tx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // RAM write port. No reset so the array can map onto block memory;
    // upper RAM address bits alias onto the same words.
    always_ff @(posedge clk) begin
        if (wr_en && (sel == SEL_RAM)) begin
            ram[ram_idx] <= WriteData;
        end
    end

    // LED register
    always_ff @(posedge clk) begin
        if (reset) begin
            led_q <= '0;
        end else if (wr_en && (sel == SEL_LED)) begin
            led_q <= WriteData[LED_W-1:0];
        end
    end

    // Free-running timer. A store replaces the increment but still counts
    // the write cycle, so the next load sees WriteData + 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q <= '0;
        end else if (wr_en && (sel == SEL_TIMER)) begin
            timer_q <= WriteData + 32'd1;
        end else begin
            timer_q <= timer_q + 32'd1;
        end
    end

    // Sticky overflow: set only when a push is dropped (full with no pop
    // on the same edge), cleared by writing 1 to its STATUS bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (fifo_push && fifo_full && !fifo_pop) begin
            ovf_q <= 1'b1;
        end else if (wr_en && (sel == SEL_STATUS) && WriteData[ST_OVF]) begin
            ovf_q <= 1'b0;
        end
    end

    // STATUS register image
    always_comb begin
        status_word                                 = '0;
        status_word[ST_FULL]                        = fifo_full;
        status_word[ST_EMPTY]                       = fifo_empty;
        status_word[ST_OVF]                         = ovf_q;
        status_word[ST_COUNT_LSB +: ST_COUNT_W]     = ST_COUNT_W'(fifo_count);
    end

    // Combinational load mux; a load in a store cycle sees the old value
    // because all state updates land on the clock edge.
    always_comb begin
        ReadData = '0;
        case (sel)
            SEL_RAM:    ReadData = ram[ram_idx];
            SEL_LED:    ReadData = 32'(led_q);
            SEL_TIMER:  ReadData = timer_q;
            SEL_STATUS: ReadData = status_word;
            default:    ReadData = '0;
        endcase
    end

endmodule

// File: tb/tb_arm_dbus_responder.sv
// Self-checking bench for arm_dbus_responder.
// A driver issues one bus cycle at a time, asks a behavioural model what the
// DUT should present during that cycle and queues the expectation. A monitor
// on the falling edge pops expectations and compares; bytes accepted by the
// model FIFO are queued separately and matched against every TX handshake.
module tb_arm_dbus_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        memWrite;
    logic [31:0] aluResult;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic [7:0]  txData;
    logic        txValid;
    logic        txReady;
    logic [7:0]  leds;

    always #5 clock = ~clock;

    arm_dbus_responder dut (
        .clk       (clock),
        .reset     (reset),
        .MemWrite  (memWrite),
        .ALUResult (aluResult),
        .WriteData (writeData),
        .ReadData  (readData),
        .tx_data   (txData),
        .tx_valid  (txValid),
        .tx_ready  (txReady),
        .leds      (leds)
    );

    typedef struct {
        bit          chkRd;
        logic [31:0] rd;
        logic [7:0]  ld;
        logic        tv;
    } exp_t;

    exp_t        expQ[$];
    logic [7:0]  txExpQ[$];

    // Behavioural model state
    logic [31:0] ramModel [64];
    bit          ramKnown [64];
    logic [7:0]  ledModel;
    logic [31:0] timerModel;
    logic [7:0]  fifoModel[$];
    bit          ovfModel;

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit isMmio(input logic [31:0] addr);
        return addr[31:16] == 16'hFFFF;
    endfunction

    // What a load from addr returns given the model state right now
    function automatic logic [31:0] modelRead(input logic [31:0] addr);
        int sz;
        sz = fifoModel.size();
        if (!isMmio(addr)) return ramModel[addr[7:2]];
        case (addr[7:2])
            6'd0:    return {24'd0, ledModel};
            6'd1:    return timerModel;
            6'd3:    return {20'd0, 4'(sz), 5'd0, ovfModel, sz == 0, sz == 8};
            default: return 32'd0;
        endcase
    endfunction

    // Advance the model across one clock edge with the given bus inputs
    task automatic updateModel(input bit rst, input bit we, input logic [31:0] addr,
                               input logic [31:0] wd, input bit rdy);
        bit wasFull;
        bit popNow;
        bit mm;
        if (rst) begin
            ledModel   = 8'd0;
            timerModel = 32'd0;
            ovfModel   = 1'b0;
            fifoModel.delete();
            txExpQ.delete();
            return;
        end
        mm      = isMmio(addr);
        wasFull = fifoModel.size() == 8;
        popNow  = rdy && fifoModel.size() > 0;
        if (we && !mm) begin
            ramModel[addr[7:2]] = wd;
            ramKnown[addr[7:2]] = 1'b1;
        end
        timerModel = (we && mm && addr[7:2] == 6'd1) ? wd + 32'd1 : timerModel + 32'd1;
        if (we && mm && addr[7:2] == 6'd0) ledModel = wd[7:0];
        if (popNow) void'(fifoModel.pop_front());
        if (we && mm && addr[7:2] == 6'd2) begin
            if (!wasFull || popNow) begin
                fifoModel.push_back(wd[7:0]);
                txExpQ.push_back(wd[7:0]);
            end else begin
                ovfModel = 1'b1;
            end
        end
        if (we && mm && addr[7:2] == 6'd3 && wd[2]) ovfModel = 1'b0;
    endtask

    // One bus cycle: entered just after a rising edge, returns just after the next
    task automatic applyStimulus(input bit rst, input bit we, input logic [31:0] addr,
                                 input logic [31:0] wd, input bit rdy);
        exp_t e;
        reset     = rst;
        memWrite  = we;
        aluResult = addr;
        writeData = wd;
        txReady   = rdy;
        e.chkRd = isMmio(addr) || ramKnown[addr[7:2]];
        e.rd    = modelRead(addr);
        e.ld    = ledModel;
        e.tv    = fifoModel.size() != 0;
        expQ.push_back(e);
        @(posedge clock);
        updateModel(rst, we, addr, wd, rdy);
        #1;
    endtask

    // Load with a fixed, hand-derived expected value as well as the model check
    task automatic probeRead(input string name, input logic [31:0] addr,
                             input logic [31:0] exp, input bit rdy);
        reset     = 1'b0;
        memWrite  = 1'b0;
        aluResult = addr;
        writeData = 32'd0;
        txReady   = rdy;
        #2;
        checkOutput(name, readData, exp);
        applyStimulus(1'b0, 1'b0, addr, 32'd0, rdy);
    endtask

    // Monitor: compares everything the DUT presents in the current cycle
    always @(negedge clock) begin
        exp_t e;
        logic [7:0] b;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            if (e.chkRd) checkOutput("ReadData", readData, e.rd);
            checkOutput("leds", {24'd0, leds}, {24'd0, e.ld});
            checkOutput("tx_valid", {31'd0, txValid}, {31'd0, e.tv});
        end
        if (txValid === 1'b1 && txReady === 1'b1) begin
            if (txExpQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL tx_unexpected: got %h expected no byte at %0t", txData, $time);
            end else begin
                b = txExpQ.pop_front();
                checkOutput("tx_data", {24'd0, txData}, {24'd0, b});
            end
        end
    end

    initial begin
        int bias;
        int r;
        logic [31:0] a;
        logic [31:0] wd;

        reset = 1'b1; memWrite = 1'b0; aluResult = 32'd0; writeData = 32'd0; txReady = 1'b0;
        for (int i = 0; i < 64; i++) ramKnown[i] = 1'b0;
        @(posedge clock);
        updateModel(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        #1;
        applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);

        // Fill RAM so every later load has a known value
        for (int i = 0; i < 64; i++) applyStimulus(1'b0, 1'b1, 32'(i * 4), $urandom, 1'b0);

        // RAM write, readback and alias
        applyStimulus(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        probeRead("ram_read", 32'h10, 32'hDEADBEEF, 1'b0);
        probeRead("ram_alias", 32'h110, 32'hDEADBEEF, 1'b0);

        // LED truncation and readback
        applyStimulus(1'b0, 1'b1, 32'hFFFF0000, 32'h1A5, 1'b0);
        checkOutput("leds_value", {24'd0, leds}, 32'h000000A5);
        probeRead("led_read", 32'hFFFF0000, 32'h000000A5, 1'b0);

        // Timer load and wrap
        applyStimulus(1'b0, 1'b1, 32'hFFFF0004, 32'hFFFFFFFE, 1'b0);
        probeRead("timer_t1", 32'hFFFF0004, 32'hFFFFFFFF, 1'b0);
        probeRead("timer_t2", 32'hFFFF0004, 32'h00000000, 1'b0);
        probeRead("timer_t3", 32'hFFFF0004, 32'h00000001, 1'b0);

        // Overfill, drain, clear overflow
        for (int i = 1; i <= 9; i++) applyStimulus(1'b0, 1'b1, 32'hFFFF0008, 32'(i), 1'b0);
        probeRead("status_full_ovf", 32'hFFFF000C, 32'h00000805, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 32'hFFFF000C, 32'd0, 1'b1);
        probeRead("status_drained", 32'hFFFF000C, 32'h00000006, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'hFFFF000C, 32'h4, 1'b0);
        probeRead("status_ovf_clr", 32'hFFFF000C, 32'h00000002, 1'b0);

        // Push and pop on the same edge while full
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 32'hFFFF0008, 32'(8'h10 + i), 1'b0);
        applyStimulus(1'b0, 1'b1, 32'hFFFF0008, 32'h55, 1'b1);
        probeRead("status_full_pp", 32'hFFFF000C, 32'h00000801, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 32'hFFFF0000, 32'd0, 1'b1);
        probeRead("status_empty", 32'hFFFF000C, 32'h00000002, 1'b0);

        // Reset in the middle of a stream, with a store that must be ignored
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 32'hFFFF0008, 32'(8'h60 + i), 1'b0);
        applyStimulus(1'b0, 1'b0, 32'hFFFF0004, 32'd0, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'hFFFF0008, 32'hAA, 1'b1);
        probeRead("status_after_rst", 32'hFFFF000C, 32'h00000002, 1'b1);
        checkOutput("tx_valid_after_rst", {31'd0, txValid}, 32'd0);
        probeRead("timer_after_rst", 32'hFFFF0004, 32'h00000001, 1'b1);

        // Randomised traffic, alternating stalled and draining consumer phases
        for (int i = 0; i < 1500; i++) begin
            bias = ((i / 150) % 2 == 0) ? 0 : 6;
            r  = $urandom_range(0, 9);
            wd = $urandom;
            case (r)
                3:       a = 32'hFFFF0000;
                4:       a = 32'hFFFF0004;
                5, 6:    a = 32'hFFFF0008;
                7:       a = 32'hFFFF000C;
                8:       a = 32'hFFFF0010 + 32'(4 * $urandom_range(0, 59));
                default: begin
                    a = $urandom;
                    if (a[31:16] == 16'hFFFF) a[31] = 1'b0;
                end
            endcase
            a[1:0] = 2'($urandom_range(0, 3));
            applyStimulus($urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)), a, wd,
                          $urandom_range(0, 9) < bias);
        end

        // Drain whatever is left
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, 32'hFFFF000C, 32'd0, 1'b1);
        @(negedge clock);
        #1;
        checkOutput("tx_leftover", 32'(txExpQ.size()), 32'd0);
        checkOutput("exp_leftover", 32'(expQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
